// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked multi-cycle ALU; iterative MUL/DIV/MOD built only with SEQ_ALU_MULDIV_EN
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carryout,
   output logic             overflow,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_ONE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_XOR = 4'b0010, OP_NOR = 4'b0011;
   localparam logic [3:0] OP_NAND = 4'b0100, OP_NOT = 4'b0101, OP_ADD = 4'b0110, OP_SUB = 4'b0111;
   localparam logic [3:0] OP_SLT = 4'b1000, OP_MUL = 4'b1001, OP_DIV = 4'b1010, OP_MOD = 4'b1011;
   localparam logic [3:0] OP_SLA = 4'b1100, OP_SRA = 4'b1101;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]         op_q, op_d;
   logic               zero_q, zero_d, neg_q, neg_d, c_q, c_d, v_q, v_d, dbz_q, dbz_d;
   logic [WIDTH:0]     sum_w, dif_w;
   logic [WIDTH-1:0]   one_res;
   logic               one_c, one_v, one_dbz;

`ifdef SEQ_ALU_MULDIV_EN
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
   // acc: product accumulator or remainder; mc: shifted multiplicand or divisor; y: multiplier or quotient
   logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, prod;
   logic [WIDTH-1:0]   y_q, y_d, ma, mb, quo, rem, fin_res;
   logic [SHW:0]       cnt_q, cnt_d;
   logic               sgn_q, sgn_d, mnov_q, mnov_d, fin_v;
   logic [WIDTH:0]     shl, diff;

   assign ma = a[WIDTH-1] ? -a : a;
   assign mb = b[WIDTH-1] ? -b : b;
`endif

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign result      = res_q;
   assign zero        = zero_q;
   assign negative    = neg_q;
   assign carryout    = c_q;
   assign overflow    = v_q;
   assign div_by_zero = dbz_q;

   always_comb begin
      sum_w   = {1'b0, a_q} + {1'b0, b_q};
      dif_w   = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
      one_res = '0;
      one_c   = 1'b0;
      one_v   = 1'b0;
      one_dbz = 1'b0;
      case (op_q)
         OP_AND:  one_res = a_q & b_q;
         OP_OR:   one_res = a_q | b_q;
         OP_XOR:  one_res = a_q ^ b_q;
         OP_NOR:  one_res = ~(a_q | b_q);
         OP_NAND: one_res = ~(a_q & b_q);
         OP_NOT:  one_res = ~a_q;
         OP_ADD: begin
            one_res = sum_w[WIDTH-1:0];
            one_c   = sum_w[WIDTH];
            one_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            one_res = dif_w[WIDTH-1:0];
            one_c   = dif_w[WIDTH];
            one_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SLT:  one_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLA:  one_res = a_q << b_q[SHW-1:0];
         OP_SRA:  one_res = $signed(a_q) >>> b_q[SHW-1:0];
         OP_MUL:  one_res = '0;
`ifdef SEQ_ALU_MULDIV_EN
         // Only a zero divisor reaches the single-cycle stage for DIV/MOD
         OP_DIV: begin
            one_res = '1;
            one_dbz = 1'b1;
         end
         OP_MOD: begin
            one_res = a_q;
            one_dbz = 1'b1;
         end
`else
         OP_DIV:  one_res = '0;
         OP_MOD:  one_res = '0;
`endif
         default: one_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      c_d     = c_q;
      v_d     = v_q;
      dbz_d   = dbz_q;
`ifdef SEQ_ALU_MULDIV_EN
      acc_d   = acc_q;
      mc_d    = mc_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      mnov_d  = mnov_q;
      shl     = '0;
      diff    = '0;
      prod    = '0;
      quo     = '0;
      rem     = '0;
      fin_res = '0;
      fin_v   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = opcode;
               state_d = S_ONE;
`ifdef SEQ_ALU_MULDIV_EN
               if (opcode == OP_MUL || ((opcode == OP_DIV || opcode == OP_MOD) && b != '0)) begin
                  state_d = S_BUSY;
                  acc_d   = '0;
                  cnt_d   = '0;
                  mnov_d  = (opcode == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                  if (opcode == OP_MUL) begin
                     mc_d  = {{WIDTH{1'b0}}, ma};
                     y_d   = mb;
                     sgn_d = a[WIDTH-1] ^ b[WIDTH-1];
                  end else begin
                     mc_d  = {{WIDTH{1'b0}}, mb};
                     y_d   = ma;
                     sgn_d = (opcode == OP_DIV) ? (a[WIDTH-1] ^ b[WIDTH-1]) : a[WIDTH-1];
                  end
               end
`endif
            end
         end
         S_ONE: begin
            res_d   = one_res;
            zero_d  = (one_res == '0);
            neg_d   = one_res[WIDTH-1];
            c_d     = one_c;
            v_d     = one_v;
            dbz_d   = one_dbz;
            state_d = S_DONE;
         end
`ifdef SEQ_ALU_MULDIV_EN
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
               acc_d   = acc_q + (y_q[0] ? mc_q : '0);
               mc_d    = mc_q << 1;
               y_d     = y_q >> 1;
               prod    = sgn_q ? -acc_d : acc_d;
               fin_res = prod[WIDTH-1:0];
               // Representable only if the upper half is a pure sign extension of bit WIDTH-1
               fin_v   = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
            end else begin
               shl     = {acc_q[WIDTH-1:0], y_q[WIDTH-1]};
               diff    = shl - {1'b0, mc_q[WIDTH-1:0]};
               acc_d   = {{WIDTH{1'b0}}, (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0])};
               y_d     = {y_q[WIDTH-2:0], ~diff[WIDTH]};
               quo     = sgn_q ? -y_d : y_d;
               rem     = sgn_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
               fin_res = (op_q == OP_DIV) ? quo : rem;
               fin_v   = (op_q == OP_DIV) && mnov_q;
            end
            if (cnt_q == CNT_LAST) begin
               res_d   = fin_res;
               zero_d  = (fin_res == '0);
               neg_d   = fin_res[WIDTH-1];
               c_d     = 1'b0;
               v_d     = fin_v;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         c_q     <= c_d;
         v_q     <= v_d;
         dbz_q   <= dbz_d;
      end
   end

`ifdef SEQ_ALU_MULDIV_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         mc_q   <= '0;
         y_q    <= '0;
         cnt_q  <= '0;
         sgn_q  <= 1'b0;
         mnov_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         mc_q   <= mc_d;
         y_q    <= y_d;
         cnt_q  <= cnt_d;
         sgn_q  <= sgn_d;
         mnov_q <= mnov_d;
      end
   end
`endif

endmodule
